// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Handshaked 16-opcode ALU with accumulator, status flags and an
//            optional iterative restoring divider (enabled by ALU_DIV_EN).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_err
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_MUL  = 4'd2;
    localparam logic [3:0] c_OP_DIV  = 4'd3;
    localparam logic [3:0] c_OP_ADDA = 4'd4;
    localparam logic [3:0] c_OP_MULA = 4'd5;
    localparam logic [3:0] c_OP_MAC  = 4'd6;
    localparam logic [3:0] c_OP_ROL  = 4'd7;
    localparam logic [3:0] c_OP_ROR  = 4'd8;
    localparam logic [3:0] c_OP_AND  = 4'd9;
    localparam logic [3:0] c_OP_OR   = 4'd10;
    localparam logic [3:0] c_OP_XOR  = 4'd11;
    localparam logic [3:0] c_OP_NAND = 4'd12;
    localparam logic [3:0] c_OP_EQ   = 4'd13;
    localparam logic [3:0] c_OP_GT   = 4'd14;
    localparam logic [3:0] c_OP_LT   = 4'd15;

    localparam logic [0:0] c_S_IDLE = 1'b0;
`ifdef ALU_DIV_EN
    localparam logic [0:0] c_S_DIV  = 1'b1;
    localparam int         CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] c_CNT_INIT = CW'(WIDTH - 1);
`endif

    logic [0:0]       r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_err;
    logic [WIDTH-1:0] r_acc;

    logic             w_accept;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_err;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_adda;
    logic [WIDTH:0]   w_mac;
    logic [WIDTH-1:0] w_mul_ab;
    logic [WIDTH-1:0] w_mul_acc;

    assign in_ready   = (r_state == c_S_IDLE) && (!r_out_valid || out_ready) && rst_n;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign flag_err   = r_err;

    // Products are sized to WIDTH so only the low half is ever built.
    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_adda    = {1'b0, r_acc} + {1'b0, a};
    assign w_mul_ab  = a * b;
    assign w_mul_acc = r_acc * a;
    assign w_mac     = {1'b0, r_acc} + {1'b0, w_mul_ab};

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (op)
            c_OP_ADD:  {w_carry, w_res} = w_sum;
            c_OP_SUB:  {w_carry, w_res} = w_diff;
            c_OP_MUL:  w_res = w_mul_ab;
            c_OP_DIV:  w_err = 1'b1;
            c_OP_ADDA: {w_carry, w_res} = w_adda;
            c_OP_MULA: w_res = w_mul_acc;
            c_OP_MAC:  {w_carry, w_res} = w_mac;
            c_OP_ROL:  w_res = {a[WIDTH-2:0], a[WIDTH-1]};
            c_OP_ROR:  w_res = {a[0], a[WIDTH-1:1]};
            c_OP_AND:  w_res = a & b;
            c_OP_OR:   w_res = a | b;
            c_OP_XOR:  w_res = a ^ b;
            c_OP_NAND: w_res = ~(a & b);
            c_OP_EQ:   w_res = {WIDTH{a == b}};
            c_OP_GT:   w_res = {WIDTH{a > b}};
            c_OP_LT:   w_res = {WIDTH{a < b}};
            default:   w_res = '0;
        endcase
    end

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_cnt;
    logic             r_dz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_div_res;

    // r_quo starts as the dividend and is shifted out MSB-first into the
    // partial remainder while quotient bits shift in at the bottom.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_trial[WIDTH];
    assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
    assign w_div_res = r_dz ? {WIDTH{1'b1}} : w_quo_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_err       <= 1'b0;
            r_acc       <= '0;
`ifdef ALU_DIV_EN
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_cnt       <= '0;
            r_dz        <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
`ifdef ALU_DIV_EN
                        if (op == c_OP_DIV) begin
                            r_state <= c_S_DIV;
                            r_rem   <= '0;
                            r_quo   <= a;
                            r_dvs   <= b;
                            r_dz    <= (b == '0);
                            r_cnt   <= c_CNT_INIT;
                        end else
`endif
                        begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_carry     <= w_carry;
                            r_err       <= w_err;
                            r_acc       <= w_res;
                        end
                    end
                end
`ifdef ALU_DIV_EN
                c_S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state     <= c_S_IDLE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_div_res;
                        r_zero      <= (w_div_res == '0);
                        r_carry     <= 1'b0;
                        r_err       <= r_dz;
                        r_acc       <= w_div_res;
                    end
                end
`endif
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
